// File: rtl/slice_controller.sv
// Frame-rate slice sequencer: detects a fast katana swipe through the active
// fruit hitbox, freezes the slice angle via split_out and keeps the score.
module slice_controller #(
    parameter int FRUIT_SIZE  = 64,
    parameter int SPEED_MIN   = 16,
    parameter int HOLD_FRAMES = 60
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [10:0] katana_x,
    input  logic [9:0]  katana_y,
    input  logic [10:0] fruit_x,
    input  logic [9:0]  fruit_y,
    input  logic        fruit_active,
    output logic        split_out,
    output logic        slice_pulse,
    output logic [7:0]  score_out,
    output logic [1:0]  state_out
);

    // state      | meaning
    // IDLE       | no fruit tracked
    // ARMED      | fruit on screen, waiting for a fast hit
    // SPLIT      | cut angle frozen, minimum hold running
    // WAIT_CLEAR | hold done, waiting for the fruit to leave
    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] ARMED      = 2'd1;
    localparam logic [1:0] SPLIT      = 2'd2;
    localparam logic [1:0] WAIT_CLEAR = 2'd3;

    localparam logic [11:0] SPEED_MIN_W = 12'(SPEED_MIN);
    localparam logic [11:0] FRUIT_W     = 12'(FRUIT_SIZE);
    localparam logic [7:0]  HOLD_INIT   = 8'(HOLD_FRAMES - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic [7:0]  score_q, score_d;
    logic        pulse_q, pulse_d;
    logic        split_q;
    logic [10:0] prev_x_q, prev_x_d;
    logic [9:0]  prev_y_q, prev_y_d;
    logic        prev_valid_q, prev_valid_d;

    logic        frame_tick;
    logic [11:0] kx, ky, px, py, fx, fy;
    logic [11:0] dx, dy, speed;
    logic        fast, hit;

    assign frame_tick = (hcount_in == 11'd1024) && (vcount_in == 10'd768);

    assign kx = {1'b0, katana_x};
    assign ky = {2'b0, katana_y};
    assign px = {1'b0, prev_x_q};
    assign py = {2'b0, prev_y_q};
    assign fx = {1'b0, fruit_x};
    assign fy = {2'b0, fruit_y};

    assign dx    = (kx >= px) ? (kx - px) : (px - kx);
    assign dy    = (ky >= py) ? (ky - py) : (py - ky);
    assign speed = dx + dy;
    assign fast  = prev_valid_q && (speed >= SPEED_MIN_W);
    assign hit   = (kx >= fx) && (kx < fx + FRUIT_W) &&
                   (ky >= fy) && (ky < fy + FRUIT_W);

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        score_d      = score_q;
        pulse_d      = 1'b0;
        prev_x_d     = prev_x_q;
        prev_y_d     = prev_y_q;
        prev_valid_d = prev_valid_q;
        if (frame_tick) begin
            prev_x_d     = katana_x;
            prev_y_d     = katana_y;
            prev_valid_d = 1'b1;
            case (state_q)
                IDLE: begin
                    if (fruit_active) state_d = ARMED;
                end
                ARMED: begin
                    // losing the fruit wins over a coincident hit
                    if (!fruit_active) begin
                        state_d = IDLE;
                    end else if (hit && fast) begin
                        state_d = SPLIT;
                        hold_d  = HOLD_INIT;
                        pulse_d = 1'b1;
                        if (score_q != 8'hFF) score_d = score_q + 8'd1;
                    end
                end
                SPLIT: begin
                    if (hold_q == 8'd0) begin
                        state_d = fruit_active ? WAIT_CLEAR : IDLE;
                    end else begin
                        hold_d = hold_q - 8'd1;
                    end
                end
                default: begin
                    if (!fruit_active) state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            hold_q       <= 8'd0;
            score_q      <= 8'd0;
            pulse_q      <= 1'b0;
            split_q      <= 1'b0;
            prev_x_q     <= 11'd0;
            prev_y_q     <= 10'd0;
            prev_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            score_q      <= score_d;
            pulse_q      <= pulse_d;
            split_q      <= (state_d == SPLIT) || (state_d == WAIT_CLEAR);
            prev_x_q     <= prev_x_d;
            prev_y_q     <= prev_y_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    assign split_out   = split_q;
    assign slice_pulse = pulse_q;
    assign score_out   = score_q;
    assign state_out   = state_q;

endmodule

// File: tb/tb_slice_controller.sv
// Directed bench for slice_controller; two instances share stimulus and
// differ only in HOLD_FRAMES (3 and 2).
module tb_slice_controller;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [10:0] katana_x;
    logic [9:0]  katana_y;
    logic [10:0] fruit_x;
    logic [9:0]  fruit_y;
    logic        fruit_active;

    logic        split3, pulse3, split2, pulse2;
    logic [7:0]  score3, score2;
    logic [1:0]  state3, state2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    slice_controller #(.FRUIT_SIZE(64), .SPEED_MIN(16), .HOLD_FRAMES(3)) u_dut3 (
        .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .katana_x(katana_x), .katana_y(katana_y), .fruit_x(fruit_x), .fruit_y(fruit_y),
        .fruit_active(fruit_active), .split_out(split3), .slice_pulse(pulse3),
        .score_out(score3), .state_out(state3)
    );

    slice_controller #(.FRUIT_SIZE(64), .SPEED_MIN(16), .HOLD_FRAMES(2)) u_dut2 (
        .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .katana_x(katana_x), .katana_y(katana_y), .fruit_x(fruit_x), .fruit_y(fruit_y),
        .fruit_active(fruit_active), .split_out(split2), .slice_pulse(pulse2),
        .score_out(score2), .state_out(state2)
    );

    task automatic idle_cycle();
        @(posedge clk_in);
        #1;
    endtask

    // one frame tick at the given katana position; returns 1 ns after the edge
    task automatic do_tick(input int kx, input int ky);
        katana_x  = 11'(kx);
        katana_y  = 10'(ky);
        hcount_in = 11'd1024;
        vcount_in = 10'd768;
        @(posedge clk_in);
        #1;
        hcount_in = 11'd0;
        vcount_in = 10'd0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; fruit_active = 1'b1; fruit_x = 11'd200; fruit_y = 10'd100;
        katana_x = 11'd0; katana_y = 10'd0; hcount_in = 11'd0; vcount_in = 10'd0;
        repeat (3) idle_cycle();
        n_checks++; if (state3 !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", state3); end
        n_checks++; if (split3 !== 1'b0) begin n_fail++; $display("FAIL reset_split got %0b exp 0", split3); end
        n_checks++; if (pulse3 !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got %0b exp 0", pulse3); end
        n_checks++; if (score3 !== 8'd0) begin n_fail++; $display("FAIL reset_score got %0d exp 0", score3); end
        rst_in = 1'b0;
        repeat (4) idle_cycle();
        n_checks++; if (state3 !== 2'd0) begin n_fail++; $display("FAIL no_tick_hold got %0d exp 0", state3); end
    endtask

    task automatic test_slow_swipe();
        do_tick(210, 130);
        n_checks++; if (state3 !== 2'd1) begin n_fail++; $display("FAIL arm_from_idle got %0d exp 1", state3); end
        do_tick(215, 132);
        n_checks++; if (state3 !== 2'd1) begin n_fail++; $display("FAIL slow_state got %0d exp 1", state3); end
        n_checks++; if (split3 !== 1'b0) begin n_fail++; $display("FAIL slow_split got %0b exp 0", split3); end
        do_tick(230, 132);
        n_checks++; if (state3 !== 2'd1) begin n_fail++; $display("FAIL speed15_state got %0d exp 1", state3); end
        n_checks++; if (pulse3 !== 1'b0) begin n_fail++; $display("FAIL speed15_pulse got %0b exp 0", pulse3); end
    endtask

    task automatic test_fast_miss();
        do_tick(300, 300);
        do_tick(400, 300);
        n_checks++; if (state3 !== 2'd1) begin n_fail++; $display("FAIL miss_state got %0d exp 1", state3); end
        n_checks++; if (split3 !== 1'b0) begin n_fail++; $display("FAIL miss_split got %0b exp 0", split3); end
        do_tick(264, 132);
        n_checks++; if (state3 !== 2'd1) begin n_fail++; $display("FAIL edge_x264_state got %0d exp 1", state3); end
        fruit_active = 1'b0;
        do_tick(263, 163);
        n_checks++; if (state3 !== 2'd0) begin n_fail++; $display("FAIL hit_no_fruit_state got %0d exp 0", state3); end
        n_checks++; if (pulse3 !== 1'b0) begin n_fail++; $display("FAIL hit_no_fruit_pulse got %0b exp 0", pulse3); end
        n_checks++; if (score3 !== 8'd0) begin n_fail++; $display("FAIL hit_no_fruit_score got %0d exp 0", score3); end
    endtask

    task automatic test_slice_hold();
        fruit_active = 1'b1;
        do_tick(150, 120);
        n_checks++; if (state3 !== 2'd1) begin n_fail++; $display("FAIL slice_arm got %0d exp 1", state3); end
        do_tick(210, 130);
        n_checks++; if (split3 !== 1'b1) begin n_fail++; $display("FAIL slice_split got %0b exp 1", split3); end
        n_checks++; if (pulse3 !== 1'b1) begin n_fail++; $display("FAIL slice_pulse got %0b exp 1", pulse3); end
        n_checks++; if (score3 !== 8'd1) begin n_fail++; $display("FAIL slice_score got %0d exp 1", score3); end
        n_checks++; if (state3 !== 2'd2) begin n_fail++; $display("FAIL slice_state got %0d exp 2", state3); end
        idle_cycle();
        n_checks++; if (pulse3 !== 1'b0) begin n_fail++; $display("FAIL pulse_clear got %0b exp 0", pulse3); end
        n_checks++; if (split3 !== 1'b1) begin n_fail++; $display("FAIL split_between got %0b exp 1", split3); end
        fruit_active = 1'b0;
        do_tick(0, 0);
        n_checks++; if (split3 !== 1'b1) begin n_fail++; $display("FAIL hold3_t1_split got %0b exp 1", split3); end
        n_checks++; if (state2 !== 2'd2) begin n_fail++; $display("FAIL hold2_t1_state got %0d exp 2", state2); end
        do_tick(0, 0);
        n_checks++; if (split3 !== 1'b1) begin n_fail++; $display("FAIL hold3_t2_split got %0b exp 1", split3); end
        n_checks++; if (state2 !== 2'd0) begin n_fail++; $display("FAIL hold2_t2_state got %0d exp 0", state2); end
        n_checks++; if (split2 !== 1'b0) begin n_fail++; $display("FAIL hold2_t2_split got %0b exp 0", split2); end
        do_tick(0, 0);
        n_checks++; if (split3 !== 1'b0) begin n_fail++; $display("FAIL hold3_t3_split got %0b exp 0", split3); end
        n_checks++; if (state3 !== 2'd0) begin n_fail++; $display("FAIL hold3_t3_state got %0d exp 0", state3); end
    endtask

    task automatic test_wait_clear();
        fruit_active = 1'b1;
        do_tick(150, 120);
        do_tick(263, 163);
        n_checks++; if (pulse2 !== 1'b1) begin n_fail++; $display("FAIL edge_hit_pulse got %0b exp 1", pulse2); end
        n_checks++; if (score2 !== 8'd2) begin n_fail++; $display("FAIL edge_hit_score got %0d exp 2", score2); end
        do_tick(0, 0);
        do_tick(0, 0);
        n_checks++; if (state2 !== 2'd3) begin n_fail++; $display("FAIL wait_clear_state got %0d exp 3", state2); end
        n_checks++; if (split2 !== 1'b1) begin n_fail++; $display("FAIL wait_clear_split got %0b exp 1", split2); end
        do_tick(0, 0); do_tick(0, 0); do_tick(0, 0);
        n_checks++; if (state3 !== 2'd3) begin n_fail++; $display("FAIL wait_clear3_state got %0d exp 3", state3); end
        n_checks++; if (split2 !== 1'b1) begin n_fail++; $display("FAIL wait_clear_t5_split got %0b exp 1", split2); end
        fruit_active = 1'b0;
        do_tick(0, 0);
        n_checks++; if (split2 !== 1'b0) begin n_fail++; $display("FAIL clear_split got %0b exp 0", split2); end
        n_checks++; if (state2 !== 2'd0) begin n_fail++; $display("FAIL clear_state got %0d exp 0", state2); end
    endtask

    task automatic one_slice();
        fruit_active = 1'b1;
        do_tick(150, 120);
        do_tick(210, 130);
        fruit_active = 1'b0;
        do_tick(0, 0); do_tick(0, 0); do_tick(0, 0);
    endtask

    task automatic test_saturation_reset();
        for (int i = 0; i < 253; i++) one_slice();
        n_checks++; if (score3 !== 8'd255) begin n_fail++; $display("FAIL score_255 got %0d exp 255", score3); end
        fruit_active = 1'b1;
        do_tick(150, 120);
        do_tick(210, 130);
        n_checks++; if (score3 !== 8'd255) begin n_fail++; $display("FAIL score_sat got %0d exp 255", score3); end
        n_checks++; if (pulse3 !== 1'b1) begin n_fail++; $display("FAIL sat_pulse got %0b exp 1", pulse3); end
        do_tick(0, 0);
        n_checks++; if (state3 !== 2'd2) begin n_fail++; $display("FAIL pre_rst_state got %0d exp 2", state3); end
        rst_in = 1'b1;
        do_tick(0, 0);
        n_checks++; if (split3 !== 1'b0) begin n_fail++; $display("FAIL rst_split got %0b exp 0", split3); end
        n_checks++; if (score3 !== 8'd0) begin n_fail++; $display("FAIL rst_score got %0d exp 0", score3); end
        n_checks++; if (state3 !== 2'd0) begin n_fail++; $display("FAIL rst_state got %0d exp 0", state3); end
        n_checks++; if (pulse3 !== 1'b0) begin n_fail++; $display("FAIL rst_pulse got %0b exp 0", pulse3); end
        rst_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_slow_swipe();
        test_fast_miss();
        test_slice_hold();
        test_wait_clear();
        test_saturation_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
